// File: rtl/sift_pkg.sv
// Shared types for the gradient-pyramid read path: lock state, requester ids
// and the conventional requester slots of the histogram engines.
package sift_pkg;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   localparam int REQ_ID_W = 3;
   typedef logic [REQ_ID_W-1:0] req_id_t;

   localparam req_id_t REQ_HIST_O1 = req_id_t'(0);
   localparam req_id_t REQ_HIST_O2 = req_id_t'(1);
   localparam req_id_t REQ_HIST_O3 = req_id_t'(2);

endpackage

// File: rtl/rr_priority_pick.sv
// One-hot picker: grants the first set request found at or after ptr_i,
// wrapping modulo N.
module rr_priority_pick #(
   parameter int N     = 3,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o
);

   always_comb begin
      int   idx;
      logic found;
      grant_o = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_i) + k;
         if (idx >= N) idx = idx - N;
         for (int j = 0; j < N; j++) begin
            if (!found && (j == idx) && req_i[j]) begin
               grant_o[j] = 1'b1;
               found      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/grad_read_arbiter.sv
// Round-robin arbiter with burst lock sharing one gradient BRAM read port;
// tracks in-flight reads and steers each returned x/y pair to its issuer.
module grad_read_arbiter
   import sift_pkg::*;
#(
   parameter int N_REQ        = 3,
   parameter int ADDR_W       = 12,
   parameter int BIT_DEPTH    = 8,
   parameter int READ_LATENCY = 2,
   parameter int MAX_BURST    = 16
) (
   input  logic                        clk,
   input  logic                        rst_in,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*ADDR_W-1:0]     req_addr,
   input  logic [N_REQ-1:0]            req_lock,
   output logic [N_REQ-1:0]            req_ready,
   output logic [ADDR_W-1:0]           bram_addr,
   input  logic signed [BIT_DEPTH-1:0] bram_x_grad,
   input  logic signed [BIT_DEPTH-1:0] bram_y_grad,
   output logic [N_REQ-1:0]            resp_valid,
   output logic signed [BIT_DEPTH-1:0] resp_x_grad,
   output logic signed [BIT_DEPTH-1:0] resp_y_grad,
   output logic                        busy
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam int DEPTH = READ_LATENCY + 1;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } track_t;

   lock_state_t           lock_state_q, lock_state_d;
   req_id_t               lock_owner_q, lock_owner_d;
   logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                  owner_idle_q, owner_idle_d;
   logic [ADDR_W-1:0]     bram_addr_q, bram_addr_d;
   logic signed [BIT_DEPTH-1:0] resp_x_q, resp_y_q;
   track_t                track_q [DEPTH];

   logic [N_REQ-1:0]      rr_grant;
   logic [N_REQ-1:0]      owner_onehot;
   logic                  owner_valid;
   logic                  hs;
   logic                  hs_lock;
   req_id_t               grant_id;
   logic [ADDR_W-1:0]     grant_addr;
   int                    grant_next_ptr;
   int                    owner_next_ptr;
   logic                  busy_int;

   rr_priority_pick #(
      .N     (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req_i   (req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (rr_grant)
   );

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_per_req
      assign owner_onehot[gi] = (lock_owner_q == req_id_t'(gi));
      assign resp_valid[gi]   = !rst_in && track_q[DEPTH-1].valid &&
                                (track_q[DEPTH-1].id == req_id_t'(gi));
   end

   assign owner_valid = |(req_valid & owner_onehot);

   // While locked only the owner can see ready; everyone else stalls.
   always_comb begin
      req_ready = '0;
      if (!rst_in) begin
         if (lock_state_q == LOCKED) req_ready = req_valid & owner_onehot;
         else                        req_ready = rr_grant;
      end
   end

   assign hs      = |(req_valid & req_ready);
   assign hs_lock = |(req_lock & req_ready);

   always_comb begin
      grant_id       = '0;
      grant_addr     = '0;
      grant_next_ptr = 0;
      owner_next_ptr = 0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req_ready[i]) begin
            grant_id       = req_id_t'(i);
            grant_addr     = req_addr[i*ADDR_W +: ADDR_W];
            grant_next_ptr = (i + 1 == N_REQ) ? 0 : i + 1;
         end
         if (owner_onehot[i]) owner_next_ptr = (i + 1 == N_REQ) ? 0 : i + 1;
      end
   end

   always_comb begin
      lock_state_d = lock_state_q;
      lock_owner_d = lock_owner_q;
      burst_cnt_d  = burst_cnt_q;
      rr_ptr_d     = rr_ptr_q;
      owner_idle_d = owner_idle_q;
      bram_addr_d  = hs ? grant_addr : bram_addr_q;
      case (lock_state_q)
         UNLOCKED: begin
            owner_idle_d = 1'b0;
            if (hs) begin
               rr_ptr_d = PTR_W'(grant_next_ptr);
               if (hs_lock && (MAX_BURST > 1)) begin
                  lock_state_d = LOCKED;
                  lock_owner_d = grant_id;
                  burst_cnt_d  = CNT_W'(1);
               end
            end
         end
         LOCKED: begin
            if (hs) begin
               owner_idle_d = 1'b0;
               rr_ptr_d     = PTR_W'(grant_next_ptr);
               // The handshake that brings the count to MAX_BURST releases the lock.
               if (!hs_lock || (burst_cnt_q == CNT_W'(MAX_BURST - 1))) begin
                  lock_state_d = UNLOCKED;
                  burst_cnt_d  = '0;
               end else begin
                  burst_cnt_d = burst_cnt_q + CNT_W'(1);
               end
            end else if (!owner_valid) begin
               if (owner_idle_q) begin
                  lock_state_d = UNLOCKED;
                  rr_ptr_d     = PTR_W'(owner_next_ptr);
                  burst_cnt_d  = '0;
                  owner_idle_d = 1'b0;
               end else begin
                  owner_idle_d = 1'b1;
               end
            end
         end
         default: lock_state_d = UNLOCKED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         lock_state_q <= UNLOCKED;
         lock_owner_q <= '0;
         burst_cnt_q  <= '0;
         rr_ptr_q     <= '0;
         owner_idle_q <= 1'b0;
         bram_addr_q  <= '0;
         resp_x_q     <= '0;
         resp_y_q     <= '0;
         for (int k = 0; k < DEPTH; k++) track_q[k] <= '0;
      end else begin
         lock_state_q <= lock_state_d;
         lock_owner_q <= lock_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         rr_ptr_q     <= rr_ptr_d;
         owner_idle_q <= owner_idle_d;
         bram_addr_q  <= bram_addr_d;
         track_q[0]   <= '{valid: hs, id: grant_id};
         for (int k = 1; k < DEPTH; k++) track_q[k] <= track_q[k-1];
         // BRAM data for a read is valid while its tag sits one stage before the end.
         if (track_q[READ_LATENCY-1].valid) begin
            resp_x_q <= bram_x_grad;
            resp_y_q <= bram_y_grad;
         end
      end
   end

   always_comb begin
      busy_int = |req_valid;
      for (int k = 0; k < DEPTH; k++) busy_int = busy_int | track_q[k].valid;
   end

   assign bram_addr   = bram_addr_q;
   assign resp_x_grad = resp_x_q;
   assign resp_y_grad = resp_y_q;
   assign busy        = busy_int;

endmodule

// File: tb/tb_grad_read_arbiter.sv
// Bench for grad_read_arbiter: directed scenarios plus random traffic, all
// outputs compared each cycle against a queue-based behavioural model.
module tb_grad_read_arbiter;

   localparam int N  = 3;
   localparam int AW = 12;
   localparam int BD = 8;
   localparam int RL = 2;
   localparam int MB = 16;

   logic                 clk = 1'b0;
   logic                 rst_in;
   logic [N-1:0]         req_valid;
   logic [N*AW-1:0]      req_addr;
   logic [N-1:0]         req_lock;
   logic [N-1:0]         req_ready;
   logic [AW-1:0]        bram_addr;
   logic signed [BD-1:0] bram_x_grad;
   logic signed [BD-1:0] bram_y_grad;
   logic [N-1:0]         resp_valid;
   logic signed [BD-1:0] resp_x_grad;
   logic signed [BD-1:0] resp_y_grad;
   logic                 busy;

   always #5 clk = ~clk;

   grad_read_arbiter #(
      .N_REQ        (N),
      .ADDR_W       (AW),
      .BIT_DEPTH    (BD),
      .READ_LATENCY (RL),
      .MAX_BURST    (MB)
   ) dut (
      .clk         (clk),
      .rst_in      (rst_in),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_lock    (req_lock),
      .req_ready   (req_ready),
      .bram_addr   (bram_addr),
      .bram_x_grad (bram_x_grad),
      .bram_y_grad (bram_y_grad),
      .resp_valid  (resp_valid),
      .resp_x_grad (resp_x_grad),
      .resp_y_grad (resp_y_grad),
      .busy        (busy)
   );

   // Gradient BRAM pair: one registered stage after bram_addr, x = addr[7:0], y = -x.
   always @(posedge clk) begin
      bram_x_grad <= bram_addr[7:0];
      bram_y_grad <= 8'(8'd0 - bram_addr[7:0]);
   end

   typedef struct {
      int            due;
      int            id;
      logic [AW-1:0] addr;
   } pend_t;

   pend_t                pq[$];
   int                   n_checks  = 0;
   int                   n_pass    = 0;
   int                   cyc       = 0;
   int                   resp_seen = 0;
   int                   m_ptr     = 0;
   int                   m_owner   = -1;
   int                   m_burst   = 0;
   int                   m_idle    = 0;
   logic [AW-1:0]        m_addr    = '0;
   logic signed [BD-1:0] m_x       = '0;
   logic signed [BD-1:0] m_y       = '0;
   logic [N-1:0]         last_ready;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic int model_grant(input logic [N-1:0] v);
      if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [N*AW-1:0] pack_addr(input int a0, input int a1, input int a2);
      return {AW'(a2), AW'(a1), AW'(a0)};
   endfunction

   // One clock cycle: drive, compare every output against the model, advance the model.
   task automatic step(input logic r, input logic [N-1:0] v, input logic [N-1:0] lk,
                       input logic [N*AW-1:0] a);
      int           g;
      logic [N-1:0] exp_ready;
      logic [N-1:0] exp_resp;
      logic         exp_busy;
      @(negedge clk);
      rst_in    = r;
      req_valid = v;
      req_lock  = lk;
      req_addr  = a;
      #1;
      g         = r ? -1 : model_grant(v);
      exp_ready = (g >= 0) ? (N'(1) << g) : '0;
      exp_busy  = (|v) || (pq.size() > 0);
      exp_resp  = '0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
         if (!r) exp_resp = N'(1) << pq[0].id;
         m_x = pq[0].addr[7:0];
         m_y = 8'(8'd0 - pq[0].addr[7:0]);
         pq.delete(0);
      end
      check_value("req_ready", 64'(req_ready), 64'(exp_ready));
      check_value("bram_addr", 64'(bram_addr), 64'(m_addr));
      check_value("resp_valid", 64'(resp_valid), 64'(exp_resp));
      check_value("resp_x_grad", 64'(resp_x_grad), 64'(m_x));
      check_value("resp_y_grad", 64'(resp_y_grad), 64'(m_y));
      check_value("busy", 64'(busy), 64'(exp_busy));
      if (resp_valid != '0) begin
         resp_seen++;
         $display("cycle %0d resp_valid=%b x=%0d y=%0d", cyc, resp_valid, resp_x_grad, resp_y_grad);
      end
      last_ready = req_ready;
      @(posedge clk);
      if (r) begin
         pq.delete();
         m_ptr   = 0;
         m_owner = -1;
         m_burst = 0;
         m_idle  = 0;
         m_addr  = '0;
         m_x     = '0;
         m_y     = '0;
      end else if (g >= 0) begin
         pend_t p;
         p.due  = cyc + RL + 1;
         p.id   = g;
         p.addr = a[g*AW +: AW];
         pq.push_back(p);
         m_addr = p.addr;
         m_ptr  = (g + 1) % N;
         if (m_owner < 0) begin
            if (lk[g]) begin
               m_owner = g;
               m_burst = 1;
               m_idle  = 0;
            end
         end else begin
            m_burst++;
            m_idle = 0;
            if (!lk[g] || m_burst == MB) m_owner = -1;
         end
      end else if (m_owner >= 0) begin
         m_idle++;
         if (m_idle == 2) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_idle  = 0;
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0);
   endtask

   initial begin
      int locked_grants;
      int resp_before;
      rst_in    = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      req_addr  = '0;
      repeat (2) @(posedge clk);

      // Reset cycle with everyone requesting: nothing may be granted.
      step(1'b1, 3'b111, 3'b000, pack_addr(1, 2, 3));

      // Single read of 0x005 by requester 0.
      step(1'b0, 3'b001, 3'b000, pack_addr('h005, 0, 0));
      idle(4);

      // Continuous requests from all three, no lock.
      for (int i = 0; i < 9; i++) step(1'b0, 3'b111, 3'b000, pack_addr(100 + i, 200 + i, 300 + i));
      idle(4);

      // Requester 1 holds a lock through the forced release at MAX_BURST.
      locked_grants = 0;
      step(1'b0, 3'b010, 3'b010, pack_addr(0, 'h40, 0));
      if (last_ready == 3'b010) locked_grants++;
      for (int i = 1; i < MB; i++) begin
         step(1'b0, 3'b111, 3'b010, pack_addr(7, 'h40 + i, 9));
         if (last_ready == 3'b010) locked_grants++;
      end
      check_value("burst_grants", 64'(locked_grants), 64'(MB));
      step(1'b0, 3'b111, 3'b000, pack_addr(7, 8, 9));
      check_value("after_burst_grant", 64'(last_ready), 64'(3'b100));
      step(1'b0, 3'b111, 3'b000, pack_addr(7, 8, 9));
      check_value("after_burst_grant2", 64'(last_ready), 64'(3'b001));
      idle(4);

      // Requester 2 locks then abandons; requester 0 waits two cycles.
      step(1'b0, 3'b100, 3'b100, pack_addr(0, 0, 'h77));
      check_value("lock2_grant", 64'(last_ready), 64'(3'b100));
      step(1'b0, 3'b001, 3'b000, pack_addr('h31, 0, 0));
      check_value("stall_1", 64'(last_ready), 64'(3'b000));
      step(1'b0, 3'b001, 3'b000, pack_addr('h31, 0, 0));
      check_value("stall_2", 64'(last_ready), 64'(3'b000));
      step(1'b0, 3'b001, 3'b000, pack_addr('h31, 0, 0));
      check_value("abandon_grant", 64'(last_ready), 64'(3'b001));
      step(1'b0, 3'b011, 3'b000, pack_addr('h32, 'h33, 0));
      check_value("ptr_after_abandon", 64'(last_ready), 64'(3'b010));
      idle(4);

      // Back-to-back reads 10, 11, 12 by 0, 1, 0.
      step(1'b0, 3'b001, 3'b000, pack_addr(10, 0, 0));
      step(1'b0, 3'b010, 3'b000, pack_addr(0, 11, 0));
      step(1'b0, 3'b001, 3'b000, pack_addr(12, 0, 0));
      idle(5);

      // Reset while two reads are in flight.
      step(1'b0, 3'b001, 3'b000, pack_addr('h20, 0, 0));
      step(1'b0, 3'b010, 3'b000, pack_addr(0, 'h21, 0));
      step(1'b1, 3'b000, 3'b000, '0);
      resp_before = resp_seen;
      idle(5);
      check_value("resp_after_reset", 64'(resp_seen - resp_before), 64'(0));
      step(1'b0, 3'b111, 3'b000, pack_addr(1, 2, 3));
      check_value("grant_after_reset", 64'(last_ready), 64'(3'b001));
      idle(4);

      // Random traffic with occasional resets, locks and abandoned locks.
      for (int i = 0; i < 600; i++) begin
         logic [N-1:0] v;
         logic [N-1:0] lk;
         logic         r;
         r = ($urandom_range(0, 99) == 0);
         for (int b = 0; b < N; b++) begin
            v[b]  = ($urandom_range(0, 9) < 6);
            lk[b] = ($urandom_range(0, 9) < 4);
         end
         step(r, v, lk, (N*AW)'({$urandom(), $urandom()}));
      end
      idle(6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
